// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, defaults and helpers for the 1-D convolution engine
package conv_pkg;

  localparam int DATA_N_DEF    = 8;
  localparam int LG_DATA_N_DEF = 3;
  localparam int FILT_N_DEF    = 4;
  localparam int LG_FILT_N_DEF = 2;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } conv_state_e;

  function automatic int y_count(input int data_n, input int filt_n);
    return data_n - filt_n + 1;
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// rtl/conv_sequencer_if.sv - sequencer bus towards the loaders, memories and MAC datapath
interface conv_sequencer_if
  import conv_pkg::*;
#(
  parameter int LG_DATA_N = LG_DATA_N_DEF,
  parameter int LG_FILT_N = LG_FILT_N_DEF
) ();

  logic                 done_x;
  logic                 done_f;
  logic                 mem_wr_state;
  logic                 frame_start;
  logic                 rd_en;
  logic [LG_DATA_N-1:0] rd_addr_x;
  logic [LG_FILT_N-1:0] rd_addr_f;
  logic                 mac_clr;
  logic                 mac_en;
  logic                 m_valid_y;
  logic                 m_ready_y;
  logic                 y_last;
  logic                 busy;

  modport master (
    input  done_x, done_f, m_ready_y,
    output mem_wr_state, frame_start, rd_en, rd_addr_x, rd_addr_f,
           mac_clr, mac_en, m_valid_y, y_last, busy
  );

  modport slave (
    output done_x, done_f, m_ready_y,
    input  mem_wr_state, frame_start, rd_en, rd_addr_x, rd_addr_f,
           mac_clr, mac_en, m_valid_y, y_last, busy
  );

endinterface

// File: rtl/conv_idx_gen.sv
// rtl/conv_idx_gen.sv - nested output (n) / tap (k) counter for the convolution sequencer
module conv_idx_gen
  import conv_pkg::*;
#(
  parameter int LG_DATA_N = LG_DATA_N_DEF,
  parameter int LG_FILT_N = LG_FILT_N_DEF,
  parameter int FILT_N    = FILT_N_DEF,
  parameter int Y_N       = y_count(DATA_N_DEF, FILT_N_DEF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_i,
  input  logic                 restart_i,
  input  logic                 advance_n_i,
  output logic [LG_DATA_N-1:0] n_o,
  output logic [LG_FILT_N-1:0] k_o,
  output logic                 k_last_o,
  output logic                 n_last_o
);

  logic [LG_DATA_N-1:0] n_q, n_d;
  logic [LG_FILT_N-1:0] k_q, k_d;

  assign k_last_o = (k_q == LG_FILT_N'(FILT_N - 1));
  assign n_last_o = (n_q == LG_DATA_N'(Y_N - 1));
  assign n_o      = n_q;
  assign k_o      = k_q;

  always_comb begin
    n_d = n_q;
    k_d = k_q;
    if (restart_i) begin
      n_d = '0;
      k_d = '0;
    end else begin
      if (step_i) k_d = k_last_o ? '0 : k_q + LG_FILT_N'(1);
      if (advance_n_i) n_d = n_q + LG_DATA_N'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0;
      k_q <= '0;
    end else begin
      n_q <= n_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - compute-phase controller: load wait, tap issue, MAC pipeline, output handshake
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_N    = DATA_N_DEF,
  parameter int LG_DATA_N = LG_DATA_N_DEF,
  parameter int FILT_N    = FILT_N_DEF,
  parameter int LG_FILT_N = LG_FILT_N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  conv_sequencer_if.master  bus
);

  localparam int Y_N = y_count(DATA_N, FILT_N);

  if (FILT_N < 1 || FILT_N > DATA_N) begin : g_bad_filt
    $error("conv_sequencer: FILT_N must lie in 1..DATA_N");
  end

  conv_state_e          state_q;
  logic                 flag_x_q, flag_f_q;
  logic                 mem_wr_q, frame_start_q, rd_en_q, busy_q;
  logic                 mac_en_q, mac_clr_q, m_valid_q, y_last_q;
  logic [LG_DATA_N-1:0] n;
  logic [LG_FILT_N-1:0] k;
  logic                 k_last, n_last, load_go, accept;

  // Either order of arrival works: the live input stands in for a not-yet-set flag.
  assign load_go = (flag_x_q | bus.done_x) & (flag_f_q | bus.done_f);
  assign accept  = (state_q == ST_OUT) & bus.m_ready_y;

  conv_idx_gen #(
    .LG_DATA_N (LG_DATA_N),
    .LG_FILT_N (LG_FILT_N),
    .FILT_N    (FILT_N),
    .Y_N       (Y_N)
  ) u_idx (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_i      (state_q == ST_ISSUE),
    .restart_i   (state_q == ST_LOAD),
    .advance_n_i (accept & ~n_last),
    .n_o         (n),
    .k_o         (k),
    .k_last_o    (k_last),
    .n_last_o    (n_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      flag_x_q      <= 1'b0;
      flag_f_q      <= 1'b0;
      mem_wr_q      <= 1'b1;
      frame_start_q <= 1'b0;
      rd_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      mac_en_q      <= 1'b0;
      mac_clr_q     <= 1'b0;
      m_valid_q     <= 1'b0;
      y_last_q      <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      // Memory data arrives one cycle after the read strobe.
      mac_en_q      <= rd_en_q;
      mac_clr_q     <= rd_en_q & (k == '0);
      case (state_q)
        ST_LOAD: begin
          flag_x_q <= flag_x_q | bus.done_x;
          flag_f_q <= flag_f_q | bus.done_f;
          if (load_go) begin
            state_q  <= ST_ISSUE;
            rd_en_q  <= 1'b1;
            busy_q   <= 1'b1;
            mem_wr_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (k_last) begin
            state_q <= ST_DRAIN;
            rd_en_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          state_q   <= ST_OUT;
          m_valid_q <= 1'b1;
          y_last_q  <= n_last;
        end
        ST_OUT: begin
          if (bus.m_ready_y) begin
            m_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
            if (n_last) begin
              state_q       <= ST_LOAD;
              flag_x_q      <= 1'b0;
              flag_f_q      <= 1'b0;
              frame_start_q <= 1'b1;
              mem_wr_q      <= 1'b1;
              busy_q        <= 1'b0;
            end else begin
              state_q <= ST_ISSUE;
              rd_en_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.mem_wr_state = mem_wr_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.rd_addr_x    = n + LG_DATA_N'(k);
  assign bus.rd_addr_f    = k;
  assign bus.mac_en       = mac_en_q;
  assign bus.mac_clr      = mac_clr_q;
  assign bus.m_valid_y    = m_valid_q;
  assign bus.y_last       = y_last_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - randomized self-checking bench for conv_sequencer (FILT_N = 4, 8, 1)
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_sequencer_if #(.LG_DATA_N(3), .LG_FILT_N(2)) i_def ();
  conv_sequencer_if #(.LG_DATA_N(3), .LG_FILT_N(3)) i_f8 ();
  conv_sequencer_if #(.LG_DATA_N(3), .LG_FILT_N(1)) i_f1 ();

  conv_sequencer #(.DATA_N(8), .LG_DATA_N(3), .FILT_N(4), .LG_FILT_N(2))
    u_def (.clk(clk), .rst_n(rst_n), .bus(i_def.master));
  conv_sequencer #(.DATA_N(8), .LG_DATA_N(3), .FILT_N(8), .LG_FILT_N(3))
    u_f8 (.clk(clk), .rst_n(rst_n), .bus(i_f8.master));
  conv_sequencer #(.DATA_N(8), .LG_DATA_N(3), .FILT_N(1), .LG_FILT_N(1))
    u_f1 (.clk(clk), .rst_n(rst_n), .bus(i_f1.master));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rd_en;
    logic [7:0] ax;
    logic [7:0] af;
    logic       mac_en, mac_clr, valid, last, busy, mem_wr, fs;
  } obs_t;

  typedef struct {
    bit rd_en;
    int ax;
    int af;
    bit mac_en, mac_clr, valid, last, ready;
  } exp_t;

  task automatic sample(input int sel, output obs_t o);
    case (sel)
      0: begin
        o.rd_en = i_def.rd_en; o.ax = 8'(i_def.rd_addr_x); o.af = 8'(i_def.rd_addr_f);
        o.mac_en = i_def.mac_en; o.mac_clr = i_def.mac_clr; o.valid = i_def.m_valid_y;
        o.last = i_def.y_last; o.busy = i_def.busy; o.mem_wr = i_def.mem_wr_state; o.fs = i_def.frame_start;
      end
      1: begin
        o.rd_en = i_f8.rd_en; o.ax = 8'(i_f8.rd_addr_x); o.af = 8'(i_f8.rd_addr_f);
        o.mac_en = i_f8.mac_en; o.mac_clr = i_f8.mac_clr; o.valid = i_f8.m_valid_y;
        o.last = i_f8.y_last; o.busy = i_f8.busy; o.mem_wr = i_f8.mem_wr_state; o.fs = i_f8.frame_start;
      end
      default: begin
        o.rd_en = i_f1.rd_en; o.ax = 8'(i_f1.rd_addr_x); o.af = 8'(i_f1.rd_addr_f);
        o.mac_en = i_f1.mac_en; o.mac_clr = i_f1.mac_clr; o.valid = i_f1.m_valid_y;
        o.last = i_f1.y_last; o.busy = i_f1.busy; o.mem_wr = i_f1.mem_wr_state; o.fs = i_f1.frame_start;
      end
    endcase
  endtask

  task automatic drive(input int sel, input logic dx, input logic df, input logic rdy);
    case (sel)
      0:       begin i_def.done_x = dx; i_def.done_f = df; i_def.m_ready_y = rdy; end
      1:       begin i_f8.done_x = dx;  i_f8.done_f = df;  i_f8.m_ready_y = rdy;  end
      default: begin i_f1.done_x = dx;  i_f1.done_f = df;  i_f1.m_ready_y = rdy;  end
    endcase
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    sample(0, o);
    n_cmp++; if (o.mem_wr !== 1'b1) begin n_bad++; $display("FAIL reset_mem_wr got %0b exp 1", o.mem_wr); end
    n_cmp++; if ({o.rd_en, o.ax, o.af, o.mac_en, o.mac_clr, o.valid, o.last, o.busy, o.fs} !== 25'd0) begin
      n_bad++; $display("FAIL reset_outputs got rd_en=%0b ax=%0d af=%0d mac=%0b%0b v=%0b l=%0b busy=%0b fs=%0b exp all 0",
                        o.rd_en, o.ax, o.af, o.mac_en, o.mac_clr, o.valid, o.last, o.busy, o.fs);
    end
    @(negedge clk); rst_n = 1'b1;
    // Abort a frame in the middle of output n=2, tap k=1.
    @(negedge clk); drive(0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b1);
    end
    sample(0, o);
    n_cmp++; if (o.rd_en !== 1'b1 || o.ax !== 8'd3 || o.af !== 8'd1) begin
      n_bad++; $display("FAIL midissue_pos got rd_en=%0b ax=%0d af=%0d exp 1/3/1", o.rd_en, o.ax, o.af);
    end
    #2 rst_n = 1'b0;
    #1 sample(0, o);
    n_cmp++; if (o.mem_wr !== 1'b1) begin n_bad++; $display("FAIL midreset_mem_wr got %0b exp 1", o.mem_wr); end
    n_cmp++; if ({o.rd_en, o.ax, o.af, o.mac_en, o.mac_clr, o.valid, o.last, o.busy, o.fs} !== 25'd0) begin
      n_bad++; $display("FAIL midreset_outputs got rd_en=%0b ax=%0d af=%0d mac=%0b%0b v=%0b l=%0b busy=%0b exp all 0",
                        o.rd_en, o.ax, o.af, o.mac_en, o.mac_clr, o.valid, o.last, o.busy);
    end
    @(negedge clk); rst_n = 1'b1; drive(0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    sample(0, o);
    n_cmp++; if (o.rd_en !== 1'b0 || o.mem_wr !== 1'b1 || o.busy !== 1'b0) begin
      n_bad++; $display("FAIL postreset_load got rd_en=%0b mem_wr=%0b busy=%0b exp 0/1/0", o.rd_en, o.mem_wr, o.busy);
    end
    // A lone done_x must not start a frame: the done_f flag was cleared by reset.
    drive(0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); sample(0, o);
    n_cmp++; if (o.rd_en !== 1'b0) begin n_bad++; $display("FAIL postreset_flags got rd_en=%0b exp 0", o.rd_en); end
    pulse_reset();
  endtask

  task automatic test_out_of_order();
    obs_t o;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      sample(0, o);
      n_cmp++; if (o.rd_en !== (c == 11)) begin n_bad++; $display("FAIL ooo_rd_en cyc %0d got %0b exp %0b", c, o.rd_en, c == 11); end
      if (c == 11) begin
        n_cmp++; if (o.ax !== 8'd0 || o.af !== 8'd0) begin n_bad++; $display("FAIL ooo_addr got %0d/%0d exp 0/0", o.ax, o.af); end
      end
      drive(0, c == 10, c == 3, 1'b0);
    end
    drive(0, 1'b0, 1'b0, 1'b0);
    pulse_reset();
  endtask

  // Expected trace built from the frame rules: FILT_N reads, one drain, then OUT until accepted.
  task automatic run_frame(input int sel, input int f, input int stall_n, input int stall_len,
                           input bit rnd, input string tag);
    exp_t q[$];
    obs_t o;
    int   y = 8 - f + 1;
    int   s;
    logic dx, df;
    for (int n = 0; n < y; n++) begin
      for (int k = 0; k < f; k++)
        q.push_back('{1'b1, n + k, k, k > 0, k == 1, 1'b0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1});
      q.push_back('{1'b0, 0, 0, 1'b1, f == 1, 1'b0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1});
      s = (n == stall_n) ? stall_len : (rnd ? $urandom_range(0, 3) : 0);
      repeat (s) q.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, n == y - 1, 1'b0});
      q.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, n == y - 1, 1'b1});
    end
    @(negedge clk); drive(sel, 1'b1, 1'b1, 1'b1);
    foreach (q[i]) begin
      @(negedge clk);
      sample(sel, o);
      n_cmp++; if (o.rd_en !== q[i].rd_en) begin n_bad++; $display("FAIL %s[%0d] rd_en got %0b exp %0b", tag, i, o.rd_en, q[i].rd_en); end
      if (q[i].rd_en) begin
        n_cmp++; if (o.ax !== 8'(q[i].ax)) begin n_bad++; $display("FAIL %s[%0d] rd_addr_x got %0d exp %0d", tag, i, o.ax, q[i].ax); end
        n_cmp++; if (o.af !== 8'(q[i].af)) begin n_bad++; $display("FAIL %s[%0d] rd_addr_f got %0d exp %0d", tag, i, o.af, q[i].af); end
      end
      n_cmp++; if (o.mac_en !== q[i].mac_en) begin n_bad++; $display("FAIL %s[%0d] mac_en got %0b exp %0b", tag, i, o.mac_en, q[i].mac_en); end
      n_cmp++; if (o.mac_clr !== q[i].mac_clr) begin n_bad++; $display("FAIL %s[%0d] mac_clr got %0b exp %0b", tag, i, o.mac_clr, q[i].mac_clr); end
      n_cmp++; if (o.valid !== q[i].valid) begin n_bad++; $display("FAIL %s[%0d] m_valid_y got %0b exp %0b", tag, i, o.valid, q[i].valid); end
      if (q[i].valid) begin
        n_cmp++; if (o.last !== q[i].last) begin n_bad++; $display("FAIL %s[%0d] y_last got %0b exp %0b", tag, i, o.last, q[i].last); end
      end
      n_cmp++; if (o.busy !== 1'b1 || o.mem_wr !== 1'b0 || o.fs !== 1'b0) begin
        n_bad++; $display("FAIL %s[%0d] busy/mem_wr/frame_start got %0b/%0b/%0b exp 1/0/0", tag, i, o.busy, o.mem_wr, o.fs);
      end
      dx = (i != q.size() - 1) && rnd && ($urandom_range(0, 1) == 1);
      df = (i != q.size() - 1) && rnd && ($urandom_range(0, 1) == 1);
      drive(sel, dx, df, q[i].ready);
    end
    @(negedge clk);
    sample(sel, o);
    n_cmp++; if (o.fs !== 1'b1 || o.mem_wr !== 1'b1 || o.busy !== 1'b0 || o.rd_en !== 1'b0 || o.valid !== 1'b0) begin
      n_bad++; $display("FAIL %s_end fs/mem_wr/busy/rd_en/valid got %0b/%0b/%0b/%0b/%0b exp 1/1/0/0/0",
                        tag, o.fs, o.mem_wr, o.busy, o.rd_en, o.valid);
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    sample(sel, o);
    n_cmp++; if (o.fs !== 1'b0 || o.rd_en !== 1'b0) begin
      n_bad++; $display("FAIL %s_idle fs/rd_en got %0b/%0b exp 0/0", tag, o.fs, o.rd_en);
    end
  endtask

  task automatic test_full_frame();
    run_frame(0, 4, -1, 0, 1'b0, "full");
  endtask

  task automatic test_backpressure();
    run_frame(0, 4, 1, 6, 1'b0, "bp");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) run_frame(0, 4, -1, 0, 1'b1, "rand");
  endtask

  task automatic test_edge_f8();
    run_frame(1, 8, -1, 0, 1'b1, "f8");
  endtask

  task automatic test_edge_f1();
    run_frame(2, 1, -1, 0, 1'b1, "f1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_out_of_order();
    test_full_frame();
    test_backpressure();
    test_back_to_back();
    test_edge_f8();
    test_edge_f1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
